// File: rtl/seg7_pkg.sv
// seg7_pkg: segment types, active-low glyph constants and the code-to-glyph lookup
package seg7_pkg;
  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t GLYPH_0 = 7'b0000001;
  localparam seg_t GLYPH_1 = 7'b1001111;
  localparam seg_t GLYPH_2 = 7'b0010010;
  localparam seg_t GLYPH_3 = 7'b0000110;
  localparam seg_t GLYPH_4 = 7'b1001100;
  localparam seg_t GLYPH_5 = 7'b0100100;
  localparam seg_t GLYPH_6 = 7'b0100000;
  localparam seg_t GLYPH_7 = 7'b0001111;
  localparam seg_t GLYPH_8 = 7'b0000000;
  localparam seg_t GLYPH_9 = 7'b0000100;
  localparam seg_t GLYPH_A = 7'b0001000;
  localparam seg_t GLYPH_B = 7'b1100000;
  localparam seg_t GLYPH_C = 7'b0110001;
  localparam seg_t GLYPH_D = 7'b1000010;
  localparam seg_t GLYPH_E = 7'b0110000;
  localparam seg_t GLYPH_F = 7'b0111000;
  localparam seg_t SEG_ALL_ON = 7'b0000000;
  localparam seg_t SEG_ALL_OFF = 7'b1111111;

  function automatic seg_t decode_hex(input logic [3:0] code, input logic hex_en);
    seg_t g;
    case (code)
      4'd0: g = GLYPH_0;
      4'd1: g = GLYPH_1;
      4'd2: g = GLYPH_2;
      4'd3: g = GLYPH_3;
      4'd4: g = GLYPH_4;
      4'd5: g = GLYPH_5;
      4'd6: g = GLYPH_6;
      4'd7: g = GLYPH_7;
      4'd8: g = GLYPH_8;
      4'd9: g = GLYPH_9;
      4'd10: g = GLYPH_A;
      4'd11: g = GLYPH_B;
      4'd12: g = GLYPH_C;
      4'd13: g = GLYPH_D;
      4'd14: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return (code > 4'd9 && !hex_en) ? SEG_ALL_OFF : g;
  endfunction
endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: combinational code-to-glyph lookup in active-low form
module seg7_glyph_rom
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] code,
  output seg_t       glyph
);
  assign glyph = decode_hex(code, HEX_EN);
endmodule

// File: rtl/seg7_decoder.sv
// seg7_decoder: registered 7-segment decoder with lamp test, blanking, polarity and range flag
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output seg_t       seg,
  output logic       bcd_err
);
  seg_t glyph, nxt;
  seg7_glyph_rom #(.HEX_EN(HEX_EN)) u_rom (.code(bcd), .glyph(glyph));
  always_comb nxt = lamp_test ? SEG_ALL_ON : blank ? SEG_ALL_OFF : glyph;
  // Everything is computed active-low and inverted once at the flop input for common-cathode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg     <= ACTIVE_LOW ? SEG_ALL_OFF : ~SEG_ALL_OFF;
      bcd_err <= 1'b0;
    end else begin
      seg     <= ACTIVE_LOW ? nxt : ~nxt;
      bcd_err <= bcd > 4'd9;
    end
  end
endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: randomized and directed checks of three decoder configurations against a table model
module tb_seg7_decoder;
  logic clk = 1'b0;
  logic rst_n, blank, lamp_test;
  logic [3:0] bcd;
  logic [6:0] s [3];
  logic e [3];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // d0: common-anode decimal, d1: common-anode hex, d2: common-cathode hex
  seg7_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) d0 (.clk(clk), .rst_n(rst_n), .bcd(bcd), .blank(blank), .lamp_test(lamp_test), .seg(s[0]), .bcd_err(e[0]));
  seg7_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) d1 (.clk(clk), .rst_n(rst_n), .bcd(bcd), .blank(blank), .lamp_test(lamp_test), .seg(s[1]), .bcd_err(e[1]));
  seg7_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) d2 (.clk(clk), .rst_n(rst_n), .bcd(bcd), .blank(blank), .lamp_test(lamp_test), .seg(s[2]), .bcd_err(e[2]));

  localparam logic [6:0] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam bit AL [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit HX [3] = '{1'b0, 1'b1, 1'b1};

  function automatic logic [6:0] model_seg(int k, logic r, logic [3:0] c, logic bl, logic lt);
    logic [6:0] v;
    v = !r ? 7'h7f : lt ? 7'h00 : bl ? 7'h7f : (c < 10 || HX[k]) ? TBL[c] : 7'h7f;
    return AL[k] ? v : ~v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; bcd = 4'd8; lamp_test = 1; blank = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (s[k] !== model_seg(k, 0, bcd, blank, lamp_test) || e[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset dut%0d: seg=%b err=%b want seg=%b err=0", k, s[k], e[k], model_seg(k, 0, bcd, blank, lamp_test));
        end
      end
    end
    rst_n = 1;
    tick();
    checks++;
    if (s[0] !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_release: seg=%b want 0000000", s[0]);
    end
    checks++;
    if (s[2] !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_release_cc: seg=%b want 1111111", s[2]);
    end
  endtask

  task automatic test_sweep();
    lamp_test = 0; blank = 0;
    for (int c = 0; c < 16; c++) begin
      bcd = 4'(c);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (s[k] !== model_seg(k, 1, bcd, 0, 0) || e[k] !== (c > 9)) begin
          errors++;
          $display("FAIL sweep dut%0d code %0d: seg=%b err=%b want seg=%b err=%b", k, c, s[k], e[k], model_seg(k, 1, bcd, 0, 0), c > 9);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [6:0] want [3] = '{7'b1111111, 7'b0000000, 7'b0000110};
    bcd = 4'd3;
    for (int p = 0; p < 3; p++) begin
      blank = p < 2; lamp_test = p == 1;
      tick();
      checks++;
      if (s[0] !== want[p]) begin
        errors++;
        $display("FAIL priority step %0d: seg=%b want %b", p, s[0], want[p]);
      end
    end
  endtask

  task automatic test_polarity();
    bcd = 4'd1; blank = 0; lamp_test = 0;
    tick();
    checks++;
    if (s[2] !== 7'b0110000) begin
      errors++;
      $display("FAIL polarity: seg=%b want 0110000", s[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] prev;
    blank = 0; lamp_test = 0; bcd = 4'd0;
    tick();
    prev = 7'b0000001;
    for (int c = 0; c < 10; c++) begin
      bcd = c[0] ? 4'd0 : 4'd9;
      #1;
      checks++;
      if (s[0] !== prev) begin
        errors++;
        $display("FAIL b2b_hold cycle %0d: seg=%b want %b", c, s[0], prev);
      end
      tick();
      prev = c[0] ? 7'b0000001 : 7'b0000100;
      checks++;
      if (s[0] !== prev) begin
        errors++;
        $display("FAIL b2b cycle %0d: seg=%b want %b", c, s[0], prev);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = $urandom_range(0, 15) != 0;
      bcd = 4'($urandom);
      blank = $urandom_range(0, 3) == 0;
      lamp_test = $urandom_range(0, 5) == 0;
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (s[k] !== model_seg(k, rst_n, bcd, blank, lamp_test) || e[k] !== (rst_n && bcd > 9)) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d: seg=%b err=%b want seg=%b err=%b", k, c, s[k], e[k],
                   model_seg(k, rst_n, bcd, blank, lamp_test), rst_n && bcd > 9);
        end
      end
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_priority();
    test_polarity();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
